// File: rtl/vec_widen_10to30.sv
// ============================================================================
// vec_widen_10to30 : packs 10-bit input words into 30-bit vectors through a
//                    two-entry output FIFO; s_last flushes a short vector.
// Revision 1.0
// ============================================================================
`default_nettype none

module vec_widen_10to30 #(
  parameter int IN_W  = 10,
  parameter int RATIO = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [IN_W-1:0]       s_data,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [IN_W*RATIO-1:0] m_data,
  output logic [1:0]            m_beats,
  output logic [15:0]           vec_count
);

  localparam int         OUT_W     = IN_W * RATIO;
  localparam logic [1:0] LAST_BEAT = 2'(RATIO - 1);

  generate
    if (RATIO < 1 || RATIO > 3) begin : g_bad_ratio
      $error("RATIO must be 1..3 so that m_beats fits in 2 bits");
    end
  endgenerate

  logic [1:0]       beat;
  logic [OUT_W-1:0] acc;

  logic [OUT_W-1:0] mem_data  [2];
  logic [1:0]       mem_beats [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;

  logic             in_xfer;
  logic             complete;
  logic             push;
  logic             pop;
  logic             head_idx;
  logic [OUT_W-1:0] vec_next;

  assign s_ready  = (count != 2'd2);
  assign m_valid  = (count != 2'd0);
  assign in_xfer  = s_valid && s_ready;
  assign complete = (beat == LAST_BEAT) || s_last;
  assign push     = in_xfer && complete;
  assign pop      = m_valid && m_ready;

  // When empty, the slot just vacated still holds the last delivered entry.
  assign head_idx = (count == 2'd0) ? ~rd_ptr : rd_ptr;
  assign m_data   = mem_data[head_idx];
  assign m_beats  = mem_beats[head_idx];

  always_comb begin
    vec_next = acc;
    vec_next[beat*IN_W +: IN_W] = s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat <= 2'd0;
      acc  <= '0;
    end else if (in_xfer) begin
      if (complete) begin
        beat <= 2'd0;
        acc  <= '0;
      end else begin
        beat <= beat + 2'd1;
        acc  <= vec_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_data[i]  <= '0;
        mem_beats[i] <= 2'd0;
      end
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
      vec_count <= 16'd0;
    end else begin
      if (push) begin
        mem_data[wr_ptr]  <= vec_next;
        mem_beats[wr_ptr] <= beat + 2'd1;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr    <= ~rd_ptr;
        vec_count <= vec_count + 16'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire
